multicycle_control: RTL and testbench

- Multi-cycle MIPS main control FSM; the producer side of the ALUOp interface consumed by the ALU control decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback cycles.
- Drives datapath mux selects, write enables, memory strobes and a 3-bit ALUOp every cycle.
- Stalls on a memory-ready handshake.

---
 rtl/multicycle_control_pkg.sv | 89 ++++++++
 rtl/multicycle_control_if.sv | 38 +++
 rtl/multicycle_control_outdec.sv | 85 ++++++++
 rtl/multicycle_control.sv | 80 ++++++++
 tb/tb_multicycle_control.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multi-cycle MIPS main control: opcodes, ALUOp codes,
// datapath select encodings, FSM states and the decoded control word.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALUOP_NONE  = 3'b000;
    localparam logic [2:0] ALUOP_RTYPE = 3'b111;
    localparam logic [2:0] ALUOP_ADD   = 3'b100;
    localparam logic [2:0] ALUOP_OR    = 3'b101;
    localparam logic [2:0] ALUOP_LUI   = 3'b011;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_RST       = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_R_EXEC    = 4'd7,
        S_I_EXEC    = 4'd8,
        S_ALU_WB    = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11
    } state_t;

    typedef enum logic [3:0] {
        CLS_R       = 4'd0,
        CLS_ADDI    = 4'd1,
        CLS_ORI     = 4'd2,
        CLS_LUI     = 4'd3,
        CLS_LW      = 4'd4,
        CLS_SW      = 4'd5,
        CLS_BEQ     = 4'd6,
        CLS_J       = 4'd7,
        CLS_ILLEGAL = 4'd8
    } opclass_t;

    typedef struct packed {
        logic       pcwrite;
        logic       pcwritecond;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [2:0] aluop;
        logic [1:0] pcsource;
        logic       instrdone;
        logic       illegalop;
    } ctrl_t;

    function automatic opclass_t decode_class(input logic [5:0] op);
        case (op)
            OP_RTYPE: return CLS_R;
            OP_ADDI:  return CLS_ADDI;
            OP_ORI:   return CLS_ORI;
            OP_LUI:   return CLS_LUI;
            OP_LW:    return CLS_LW;
            OP_SW:    return CLS_SW;
            OP_BEQ:   return CLS_BEQ;
            OP_J:     return CLS_J;
            default:  return CLS_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the main control FSM (master) and the datapath (slave).
interface multicycle_control_if #(
    parameter int ALUOP_W = 3,
    parameter int STATE_W = 4
);
    logic [5:0]         Opcode;
    logic               MemReady;
    logic               PCWrite;
    logic               PCWriteCond;
    logic               IorD;
    logic               MemRead;
    logic               MemWrite;
    logic               IRWrite;
    logic               MemtoReg;
    logic               RegDst;
    logic               RegWrite;
    logic               ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [ALUOP_W-1:0] ALUOp;
    logic [1:0]         PCSource;
    logic               InstrDone;
    logic               IllegalOp;
    logic [STATE_W-1:0] State;

    modport master (
        input  Opcode, MemReady,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
               RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, InstrDone,
               IllegalOp, State
    );

    modport slave (
        output Opcode, MemReady,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
               RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, InstrDone,
               IllegalOp, State
    );
endinterface

// File: rtl/multicycle_control_outdec.sv
// Combinational state + latched opcode class -> datapath control word.
module multicycle_control_outdec
    import mips_ctrl_pkg::*;
(
    input  state_t   state,
    input  opclass_t cls,
    input  opclass_t deccls,
    input  logic     memready,
    output ctrl_t    ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.memread = 1'b1;
                ctrl.alusrcb = SRCB_FOUR;
                ctrl.aluop   = ALUOP_ADD;
                ctrl.irwrite = memready;
                ctrl.pcwrite = memready;
            end
            S_DECODE: begin
                ctrl.alusrcb = SRCB_IMMSH;
                ctrl.aluop   = ALUOP_ADD;
                if (deccls == CLS_ILLEGAL) begin
                    ctrl.illegalop = 1'b1;
                    ctrl.instrdone = 1'b1;
                end
            end
            S_MEM_ADDR: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = ALUOP_ADD;
            end
            S_MEM_READ: begin
                ctrl.memread = 1'b1;
                ctrl.iord    = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.regwrite  = 1'b1;
                ctrl.memtoreg  = 1'b1;
                ctrl.instrdone = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl.memwrite  = 1'b1;
                ctrl.iord      = 1'b1;
                ctrl.instrdone = memready;
            end
            S_R_EXEC: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_B;
                ctrl.aluop   = ALUOP_RTYPE;
            end
            S_I_EXEC: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                case (cls)
                    CLS_ORI: ctrl.aluop = ALUOP_OR;
                    CLS_LUI: ctrl.aluop = ALUOP_LUI;
                    default: ctrl.aluop = ALUOP_ADD;
                endcase
            end
            S_ALU_WB: begin
                ctrl.regwrite  = 1'b1;
                ctrl.regdst    = (cls == CLS_R);
                ctrl.instrdone = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alusrca     = 1'b1;
                ctrl.alusrcb     = SRCB_B;
                ctrl.aluop       = ALUOP_SUB;
                ctrl.pcsource    = PCSRC_ALUOUT;
                ctrl.pcwritecond = 1'b1;
                ctrl.instrdone   = 1'b1;
            end
            S_JUMP: begin
                ctrl.pcsource  = PCSRC_JUMP;
                ctrl.pcwrite   = 1'b1;
                ctrl.instrdone = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control FSM; sequences fetch/decode/execute/memory/writeback
// and stalls on MemReady.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int ALUOP_W = 3,
    parameter int STATE_W = 4
) (
    input logic                 clk,
    input logic                 reset,
    multicycle_control_if.master bus
);

    state_t   state;
    opclass_t cls;
    opclass_t deccls;
    ctrl_t    ctrl;

    assign deccls = decode_class(bus.Opcode);

    // The opcode class is captured in DECODE so later states need no valid Opcode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_RST;
            cls   <= CLS_R;
        end else begin
            case (state)
                S_RST:       state <= S_FETCH;
                S_FETCH:     if (bus.MemReady) state <= S_DECODE;
                S_DECODE: begin
                    cls <= deccls;
                    case (deccls)
                        CLS_LW, CLS_SW:              state <= S_MEM_ADDR;
                        CLS_R:                       state <= S_R_EXEC;
                        CLS_ADDI, CLS_ORI, CLS_LUI:  state <= S_I_EXEC;
                        CLS_BEQ:                     state <= S_BRANCH;
                        CLS_J:                       state <= S_JUMP;
                        default:                     state <= S_FETCH;
                    endcase
                end
                S_MEM_ADDR:  state <= (cls == CLS_LW) ? S_MEM_READ : S_MEM_WRITE;
                S_MEM_READ:  if (bus.MemReady) state <= S_MEM_WB;
                S_MEM_WB:    state <= S_FETCH;
                S_MEM_WRITE: if (bus.MemReady) state <= S_FETCH;
                S_R_EXEC:    state <= S_ALU_WB;
                S_I_EXEC:    state <= S_ALU_WB;
                S_ALU_WB:    state <= S_FETCH;
                S_BRANCH:    state <= S_FETCH;
                S_JUMP:      state <= S_FETCH;
                default:     state <= S_FETCH;
            endcase
        end
    end

    multicycle_control_outdec u_outdec (
        .state    (state),
        .cls      (cls),
        .deccls   (deccls),
        .memready (bus.MemReady),
        .ctrl     (ctrl)
    );

    assign bus.PCWrite     = ctrl.pcwrite;
    assign bus.PCWriteCond = ctrl.pcwritecond;
    assign bus.IorD        = ctrl.iord;
    assign bus.MemRead     = ctrl.memread;
    assign bus.MemWrite    = ctrl.memwrite;
    assign bus.IRWrite     = ctrl.irwrite;
    assign bus.MemtoReg    = ctrl.memtoreg;
    assign bus.RegDst      = ctrl.regdst;
    assign bus.RegWrite    = ctrl.regwrite;
    assign bus.ALUSrcA     = ctrl.alusrca;
    assign bus.ALUSrcB     = ctrl.alusrcb;
    assign bus.ALUOp       = ALUOP_W'(ctrl.aluop);
    assign bus.PCSource    = ctrl.pcsource;
    assign bus.InstrDone   = ctrl.instrdone;
    assign bus.IllegalOp   = ctrl.illegalop;
    assign bus.State       = STATE_W'(state);

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-instruction expected summaries are
// queued by the driver and compared by a monitor on each InstrDone pulse.
module tb_multicycle_control;
    import mips_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    multicycle_control_if #(.ALUOP_W(3), .STATE_W(4)) bus ();

    multicycle_control #(.ALUOP_W(3), .STATE_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int cycles;
        int memReads;
        int memWrites;
        int regWrites;
        int irWrites;
        int pcWrites;
        int pcConds;
        int illegals;
        int execAluOp;
        int execSrcB;
        int regDst;
        int memToReg;
        int donePcSrc;
        int doneState;
    } instrRec_t;

    instrRec_t expQ[$];
    int errors = 0;
    int checks = 0;
    bit monitorOn = 1'b0;

    logic [18:0] outs;
    assign outs = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                   bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
                   bus.ALUSrcB, bus.ALUOp, bus.PCSource, bus.InstrDone, bus.IllegalOp};

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: what one instruction should look like, from its opcode and stalls.
    function automatic instrRec_t model(input logic [5:0] op, input int fs, input int ms);
        instrRec_t r;
        r = '{default: 0};
        r.irWrites = 1;
        r.pcWrites = 1;
        r.memReads = fs + 1;
        r.cycles   = fs + 2;
        r.doneState = int'(S_DECODE);
        case (op)
            OP_LW: begin
                r.cycles += 3 + ms;
                r.memReads += ms + 1;
                r.regWrites = 1;
                r.memToReg = 1;
                r.execAluOp = int'(ALUOP_ADD);
                r.execSrcB = 2;
                r.doneState = int'(S_MEM_WB);
            end
            OP_SW: begin
                r.cycles += 2 + ms;
                r.memWrites = ms + 1;
                r.execAluOp = int'(ALUOP_ADD);
                r.execSrcB = 2;
                r.doneState = int'(S_MEM_WRITE);
            end
            OP_RTYPE, OP_ADDI, OP_ORI, OP_LUI: begin
                r.cycles += 2;
                r.regWrites = 1;
                r.doneState = int'(S_ALU_WB);
                r.execSrcB = (op == OP_RTYPE) ? 0 : 2;
                r.regDst = (op == OP_RTYPE) ? 1 : 0;
                r.execAluOp = (op == OP_RTYPE) ? int'(ALUOP_RTYPE) :
                              (op == OP_ORI)   ? int'(ALUOP_OR)    :
                              (op == OP_LUI)   ? int'(ALUOP_LUI)   : int'(ALUOP_ADD);
            end
            OP_BEQ: begin
                r.cycles += 1;
                r.pcConds = 1;
                r.execAluOp = int'(ALUOP_SUB);
                r.donePcSrc = 1;
                r.doneState = int'(S_BRANCH);
            end
            OP_J: begin
                r.cycles += 1;
                r.pcWrites = 2;
                r.donePcSrc = 2;
                r.doneState = int'(S_JUMP);
            end
            default: r.illegals = 1;
        endcase
        return r;
    endfunction

    function automatic bit isLegal(input logic [5:0] op);
        return op inside {OP_RTYPE, OP_ADDI, OP_ORI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_J};
    endfunction

    task automatic driveCycle(input logic mr);
        bus.MemReady = mr;
        @(posedge clk);
        #1;
    endtask

    // Issues one instruction: fs stall cycles in fetch, ms in the memory access.
    task automatic applyStimulus(input logic [5:0] op, input int fs, input int ms);
        instrRec_t r;
        r = model(op, fs, ms);
        expQ.push_back(r);
        bus.Opcode = op;
        repeat (fs) driveCycle(1'b0);
        driveCycle(1'b1);
        if (op == OP_LW || op == OP_SW) begin
            repeat (2) driveCycle(1'($urandom_range(0, 1)));
            repeat (ms) driveCycle(1'b0);
            driveCycle(1'b1);
            if (op == OP_LW) driveCycle(1'($urandom_range(0, 1)));
        end else begin
            repeat (r.cycles - fs - 1) driveCycle(1'($urandom_range(0, 1)));
        end
    endtask

    int aCycles, aMemReads, aMemWrites, aRegWrites, aIrWrites, aPcWrites, aPcConds, aIllegals;
    int aExecAluOp, aExecSrcB, aRegDst, aMemToReg;
    bit aSeenExec;

    task automatic clearAcc();
        aCycles = 0; aMemReads = 0; aMemWrites = 0; aRegWrites = 0; aIrWrites = 0;
        aPcWrites = 0; aPcConds = 0; aIllegals = 0; aExecAluOp = 0; aExecSrcB = 0;
        aRegDst = 0; aMemToReg = 0; aSeenExec = 1'b0;
    endtask

    initial begin
        instrRec_t e;
        clearAcc();
        forever begin
            @(negedge clk);
            if (monitorOn && reset && bus.State != 4'(S_RST)) begin
                aCycles++;
                aMemReads  += int'(bus.MemRead);
                aMemWrites += int'(bus.MemWrite);
                aRegWrites += int'(bus.RegWrite);
                aIrWrites  += int'(bus.IRWrite);
                aPcWrites  += int'(bus.PCWrite);
                aPcConds   += int'(bus.PCWriteCond);
                aIllegals  += int'(bus.IllegalOp);
                if (bus.ALUSrcA && !aSeenExec) begin
                    aSeenExec = 1'b1;
                    aExecAluOp = int'(bus.ALUOp);
                    aExecSrcB = int'(bus.ALUSrcB);
                end
                if (bus.RegWrite) begin
                    aRegDst = int'(bus.RegDst);
                    aMemToReg = int'(bus.MemtoReg);
                end
                checkOutput("memread-memwrite-exclusive", int'(bus.MemRead & bus.MemWrite), 0);
                if (bus.InstrDone) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected-instrdone", 1, 0);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("cycles", aCycles, e.cycles);
                        checkOutput("memread-cycles", aMemReads, e.memReads);
                        checkOutput("memwrite-cycles", aMemWrites, e.memWrites);
                        checkOutput("regwrite-count", aRegWrites, e.regWrites);
                        checkOutput("irwrite-count", aIrWrites, e.irWrites);
                        checkOutput("pcwrite-count", aPcWrites, e.pcWrites);
                        checkOutput("pcwritecond-count", aPcConds, e.pcConds);
                        checkOutput("illegalop-count", aIllegals, e.illegals);
                        checkOutput("exec-aluop", aExecAluOp, e.execAluOp);
                        checkOutput("exec-alusrcb", aExecSrcB, e.execSrcB);
                        checkOutput("wb-regdst", aRegDst, e.regDst);
                        checkOutput("wb-memtoreg", aMemToReg, e.memToReg);
                        checkOutput("done-pcsource", int'(bus.PCSource), e.donePcSrc);
                        checkOutput("done-state", int'(bus.State), e.doneState);
                    end
                    clearAcc();
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [5:0] legalOps [8];
        logic [5:0] op;
        legalOps = '{OP_RTYPE, OP_ADDI, OP_ORI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_J};
        bus.Opcode = 6'b0;
        bus.MemReady = 1'b1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset-outputs", int'(outs), 0);
        checkOutput("reset-state", int'(bus.State), int'(S_RST));
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post-reset-state", int'(bus.State), int'(S_FETCH));
        checkOutput("post-reset-memread", int'(bus.MemRead), 1);
        monitorOn = 1'b1;

        applyStimulus(OP_LW, 0, 0);
        applyStimulus(OP_SW, 3, 2);
        applyStimulus(OP_RTYPE, 0, 0);
        applyStimulus(OP_ORI, 0, 0);
        applyStimulus(OP_LUI, 1, 0);
        applyStimulus(OP_ADDI, 0, 0);
        applyStimulus(OP_BEQ, 0, 0);
        applyStimulus(OP_J, 0, 0);
        applyStimulus(6'b111111, 0, 0);
        applyStimulus(OP_LW, 2, 3);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 8) == 8) begin
                op = 6'($urandom_range(0, 63));
                while (isLegal(op)) op = 6'($urandom_range(0, 63));
            end else begin
                op = legalOps[$urandom_range(0, 7)];
            end
            applyStimulus(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        monitorOn = 1'b0;
        checkOutput("queue-drained", expQ.size(), 0);

        // Abort a load while it waits in MEM_READ.
        bus.Opcode = OP_LW;
        driveCycle(1'b1);
        driveCycle(1'b0);
        driveCycle(1'b0);
        driveCycle(1'b0);
        checkOutput("abort-pre-state", int'(bus.State), int'(S_MEM_READ));
        checkOutput("abort-pre-memread", int'(bus.MemRead), 1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("abort-outputs", int'(outs), 0);
        checkOutput("abort-state", int'(bus.State), int'(S_RST));
        @(posedge clk);
        #1;
        checkOutput("abort-held-state", int'(bus.State), int'(S_RST));
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("release-state", int'(bus.State), int'(S_FETCH));
        checkOutput("release-memread", int'(bus.MemRead), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
